// File: rtl/ieee_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : ieee_divider_if
// Purpose  : start/done handshake and operand/result bundle for ieee_divider.
//            The dz flag exists only when IEEE_DIV_DIVZ_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface ieee_divider_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic         ovrf;
  logic         undrf;
`ifdef IEEE_DIV_DIVZ_EN
  logic         dz;

  modport master (output start, a, b, input busy, done, out, ovrf, undrf, dz);
  modport slave  (input start, a, b, output busy, done, out, ovrf, undrf, dz);
`else
  modport master (output start, a, b, input busy, done, out, ovrf, undrf);
  modport slave  (input start, a, b, output busy, done, out, ovrf, undrf);
`endif
endinterface
`default_nettype wire

// File: rtl/ieee_divider.sv
`default_nettype none
// ============================================================================
// Module   : ieee_divider
// Purpose  : Sequential IEEE-754 divider, restoring radix-2, one quotient bit
//            per clock; truncating, flush-to-zero, saturate-to-infinity.
//            Optional IEEE_DIV_DIVZ_EN adds a separate divide-by-zero flag.
// Revision : 1.0  initial release
// ============================================================================
module ieee_divider #(
  parameter int N = 32,
  parameter int M = 23,
  parameter int E = 8,
  parameter int B = 127,
  parameter int O = 255
) (
  input  logic           clk,
  input  logic           rst,
  ieee_divider_if.slave  bus
);

  localparam int                CW       = $clog2(M + 3);
  localparam logic [CW-1:0]     CNT_INIT = CW'(M + 2);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic signed [E+1:0] EXP_BIAS = (E+2)'(B);
  localparam logic signed [E+1:0] EXP_MAX  = (E+2)'(O);
  localparam logic signed [E+1:0] EXP_ONE  = (E+2)'(1);
  localparam logic signed [E+1:0] EXP_ZERO = '0;
  localparam logic [E-1:0]      EXP_INF  = E'(O);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_NORM   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state, state_next;
  logic   accept;

  logic                  sign;
  logic signed [E+1:0]   exp_q;
  logic [M+1:0]          rem;
  logic [M:0]            div;
  logic [M+1:0]          quo;
  logic [CW-1:0]         cnt;
  logic [M-1:0]          mant;
  logic                  a_zero;
  logic                  b_zero;

  logic                  done_q;
  logic [N-1:0]          out_q;
  logic                  ovrf_q;
  logic                  undrf_q;

  logic [E-1:0]          ea;
  logic [E-1:0]          eb;
  logic signed [E+1:0]   exp_init;
  logic                  rem_ge;

  logic [N-1:0]          res_out;
  logic                  res_ovrf;
  logic                  res_undrf;
`ifdef IEEE_DIV_DIVZ_EN
  logic                  dz_q;
  logic                  res_dz;
`endif

  assign ea       = bus.a[N-2 -: E];
  assign eb       = bus.b[N-2 -: E];
  assign exp_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EXP_BIAS;
  assign rem_ge   = (rem >= {1'b0, div});

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (cnt == CNT_ONE) begin
          state_next = S_NORM;
        end
      end
      S_NORM:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Special operands are captured at acceptance; the iteration still runs so
  // latency never depends on the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign   <= 1'b0;
      exp_q  <= '0;
      rem    <= '0;
      div    <= '0;
      quo    <= '0;
      cnt    <= '0;
      mant   <= '0;
      a_zero <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sign   <= bus.a[N-1] ^ bus.b[N-1];
            exp_q  <= exp_init;
            rem    <= {1'b0, 1'b1, bus.a[M-1:0]};
            div    <= {1'b1, bus.b[M-1:0]};
            quo    <= '0;
            cnt    <= CNT_INIT;
            a_zero <= (ea == '0);
            b_zero <= (eb == '0);
          end
        end
        S_DIVIDE: begin
          // Remainder after subtraction is below div, so the shifted-out MSB is always 0.
          rem <= (rem_ge ? (rem - {1'b0, div}) : rem) << 1;
          quo <= {quo[M:0], rem_ge};
          cnt <= cnt - CNT_ONE;
        end
        S_NORM: begin
          if (quo[M+1]) begin
            mant <= quo[M:1];
          end else begin
            mant  <= quo[M-1:0];
            exp_q <= exp_q - EXP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    res_out   = {sign, {E{1'b0}}, {M{1'b0}}};
    res_ovrf  = 1'b0;
    res_undrf = 1'b0;
`ifdef IEEE_DIV_DIVZ_EN
    res_dz    = 1'b0;
`endif
    if (a_zero) begin
      res_out = {sign, {E{1'b0}}, {M{1'b0}}};
    end else if (b_zero) begin
      res_out = {sign, EXP_INF, {M{1'b0}}};
`ifdef IEEE_DIV_DIVZ_EN
      res_dz   = 1'b1;
`else
      res_ovrf = 1'b1;
`endif
    end else if (exp_q >= EXP_MAX) begin
      res_out  = {sign, EXP_INF, {M{1'b0}}};
      res_ovrf = 1'b1;
    end else if (exp_q <= EXP_ZERO) begin
      res_out   = {sign, {E{1'b0}}, {M{1'b0}}};
      res_undrf = 1'b1;
    end else begin
      res_out = {sign, exp_q[E-1:0], mant};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      out_q   <= '0;
      ovrf_q  <= 1'b0;
      undrf_q <= 1'b0;
`ifdef IEEE_DIV_DIVZ_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state == S_DONE) begin
        done_q  <= 1'b1;
        out_q   <= res_out;
        ovrf_q  <= res_ovrf;
        undrf_q <= res_undrf;
`ifdef IEEE_DIV_DIVZ_EN
        dz_q    <= res_dz;
`endif
      end
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.ovrf  = ovrf_q;
  assign bus.undrf = undrf_q;
`ifdef IEEE_DIV_DIVZ_EN
  assign bus.dz    = dz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ieee_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_ieee_divider
// Purpose  : scoreboard bench for ieee_divider; directed and random divisions
//            checked against an integer-division reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ieee_divider;
  localparam int N = 32, M = 23, E = 8, B = 127, O = 255;
  localparam int LAT = M + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ieee_divider_if #(.N(N)) bus ();

  ieee_divider #(.N(N), .M(M), .E(E), .B(B), .O(O)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] out;
    logic        ovrf;
    logic        undrf;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] o, input logic ov, input logic un, input logic z);
    exp_t r;
    r.out = o; r.ovrf = ov; r.undrf = un; r.dz = z; r.acc = 0;
    return r;
  endfunction

  // Reference: quotient of the significands as a plain integer division.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t              r;
    logic              s;
    int                ea, eb, e;
    longint unsigned   num, den, q, mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r  = mk({s, 31'b0}, 1'b0, 1'b0, 1'b0);
    if (ea == 0) begin
      r.out = {s, 31'b0};
    end else if (eb == 0) begin
      r.out = {s, 8'hFF, 23'b0};
`ifdef IEEE_DIV_DIVZ_EN
      r.dz = 1'b1;
`else
      r.ovrf = 1'b1;
`endif
    end else begin
      num = (longint'(a[22:0]) + (64'd1 << M)) << (M + 1);
      den = longint'(b[22:0]) + (64'd1 << M);
      q   = num / den;
      if (q >= (64'd1 << (M + 1))) begin
        mant = q >> 1;
        e    = ea - eb + B;
      end else begin
        mant = q;
        e    = ea - eb + B - 1;
      end
      if (e >= O) begin
        r.out = {s, 8'hFF, 23'b0}; r.ovrf = 1'b1;
      end else if (e <= 0) begin
        r.out = {s, 31'b0}; r.undrf = 1'b1;
      end else begin
        r.out = {s, e[7:0], mant[22:0]};
      end
    end
    return r;
  endfunction

  // Monitor: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("out", bus.out, mon_e.out);
        check("ovrf", bus.ovrf, mon_e.ovrf);
        check("undrf", bus.undrf, mon_e.undrf);
`ifdef IEEE_DIV_DIVZ_EN
        check("dz", bus.dz, mon_e.dz);
`endif
        check("busy_at_done", bus.busy, 1'b0);
        check("latency", cyc - mon_e.acc, LAT);
      end
    end
  end

  // Called at a negedge with the DUT idle or in its done cycle.
  task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    check("busy_after_accept", bus.busy, 1'b1);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    issue_exp(a, b, model(a, b));
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * LAT && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", 2 * LAT);
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 15) == 0) v[30:23] = 8'd0;
    else if ($urandom_range(0, 1) == 1) v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_out", bus.out, 32'h0);
    check("rst_ovrf", bus.ovrf, 1'b0);
    check("rst_undrf", bus.undrf, 1'b0);
`ifdef IEEE_DIV_DIVZ_EN
    check("rst_dz", bus.dz, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 6/2, with a start pulse during busy that must be ignored
    issue_exp(32'h40C00000, 32'h40000000, mk(32'h40400000, 1'b0, 1'b0, 1'b0));
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40400000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Back-to-back directed vectors, each issued in the previous done cycle
    issue_exp(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 1'b0, 1'b0, 1'b0));
    wait_done();
    issue_exp(32'hBF800000, 32'h3F000000, mk(32'hC0000000, 1'b0, 1'b0, 1'b0));
    wait_done();
    issue_exp(32'h7F000000, 32'h3E800000, mk(32'h7F800000, 1'b1, 1'b0, 1'b0));
    wait_done();
    issue_exp(32'h00800000, 32'h40000000, mk(32'h00000000, 1'b0, 1'b1, 1'b0));
    wait_done();
    issue_exp(32'h00000000, 32'h40000000, mk(32'h00000000, 1'b0, 1'b0, 1'b0));
    wait_done();
`ifdef IEEE_DIV_DIVZ_EN
    issue_exp(32'h3F800000, 32'h00000000, mk(32'h7F800000, 1'b0, 1'b0, 1'b1));
`else
    issue_exp(32'h3F800000, 32'h00000000, mk(32'h7F800000, 1'b1, 1'b0, 1'b0));
`endif
    wait_done();

    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      issue(rand_op(), rand_op());
      wait_done();
    end

    // Reset mid-operation: outputs clear and the operation is dropped
    issue(32'h40C00000, 32'h40000000);
    wait_done();
    issue(32'h3F800000, 32'h40400000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_out", bus.out, 32'h0);
    check("midrst_ovrf", bus.ovrf, 1'b0);
    check("midrst_undrf", bus.undrf, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    issue(32'h40C00000, 32'h40000000);
    wait_done();

    @(negedge clk);
    check("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
